// File: rtl/collapse_arbiter.sv
// collapse_arbiter: two-requester round-robin front end for a destructive-read cell bank.
// One command in flight; each INIT arms a cell, and the first READ after it consumes the cell.
module collapse_arbiter #(
  parameter int N        = 64,
  parameter int DATA_W   = 256,
  parameter int BASIS_W  = 8,
  parameter int ADDR_W   = $clog2(N),
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_op,
  input  logic [2*ADDR_W-1:0]    req_addr,
  input  logic [2*DATA_W-1:0]    req_value,
  input  logic [2*BASIS_W-1:0]   req_basis,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [1:0]             rsp_status,
  output logic [ADDR_W-1:0]      bank_init_addr,
  output logic [DATA_W-1:0]      bank_init_value,
  output logic [BASIS_W-1:0]     bank_init_basis,
  output logic                   bank_init_strobe,
  output logic [ADDR_W-1:0]      bank_read_addr,
  output logic [BASIS_W-1:0]     bank_basis,
  output logic                   bank_read_pulse,
  input  logic [DATA_W-1:0]      bank_data,
  input  logic [N-1:0]           bank_mismatch_vec,
  output logic [N-1:0]           armed_vec
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] ST_OK = 2'b00, ST_MIS = 2'b01, ST_EMPTY = 2'b10;
  localparam logic [1:0] CNT_LAST = 2'(READ_LAT - 1);
  state_t              state_q, state_d;
  logic                en_q, en_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic [BASIS_W-1:0]  basis_q, basis_d;
  logic [N-1:0]        armed_q, armed_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          status_q, status_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                gnt;
  logic                rd_bus;
  // the requester not served last wins a tie; last_q resets to 1 so requester 0 goes first
  assign gnt = (&req_valid) ? ~last_q : ~req_valid[0];
  always_comb begin
    state_d          = state_q;
    en_d             = 1'b1;
    last_d           = last_q;
    gnt_d            = gnt_q;
    op_d             = op_q;
    addr_d           = addr_q;
    value_d          = value_q;
    basis_d          = basis_q;
    armed_d          = armed_q;
    data_d           = data_q;
    status_d         = status_q;
    cnt_d            = cnt_q;
    req_ready        = '0;
    rsp_valid        = '0;
    bank_init_strobe = 1'b0;
    bank_read_pulse  = 1'b0;
    case (state_q)
      IDLE: if (en_q && |req_valid) begin
        req_ready[gnt] = 1'b1;
        gnt_d          = gnt;
        last_d         = gnt;
        op_d           = req_op[gnt];
        addr_d         = gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        value_d        = gnt ? req_value[2*DATA_W-1:DATA_W] : req_value[DATA_W-1:0];
        basis_d        = gnt ? req_basis[2*BASIS_W-1:BASIS_W] : req_basis[BASIS_W-1:0];
        state_d        = ISSUE;
      end
      ISSUE: if (!op_q) begin
        bank_init_strobe = 1'b1;
        armed_d[addr_q]  = 1'b1;
        data_d           = '0;
        status_d         = ST_OK;
        state_d          = RESP;
      end else if (!armed_q[addr_q]) begin
        data_d   = '0;
        status_d = ST_EMPTY;
        state_d  = RESP;
      end else begin
        bank_read_pulse = 1'b1;
        armed_d[addr_q] = 1'b0;
        cnt_d           = '0;
        state_d         = WAIT;
      end
      WAIT: if (cnt_q == CNT_LAST) begin
        data_d   = bank_data;
        status_d = bank_mismatch_vec[addr_q] ? ST_MIS : ST_OK;
        state_d  = RESP;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          data_d   = '0;
          status_d = ST_OK;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      value_q  <= '0;
      basis_q  <= '0;
      armed_q  <= '0;
      data_q   <= '0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      value_q  <= value_d;
      basis_q  <= basis_d;
      armed_q  <= armed_d;
      data_q   <= data_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end
  // read bus is live from the pulse through the capture cycle only
  assign rd_bus          = bank_read_pulse || state_q == WAIT;
  assign bank_read_addr  = rd_bus ? addr_q : '0;
  assign bank_basis      = rd_bus ? basis_q : '0;
  assign bank_init_addr  = bank_init_strobe ? addr_q : '0;
  assign bank_init_value = bank_init_strobe ? value_q : '0;
  assign bank_init_basis = bank_init_strobe ? basis_q : '0;
  assign rsp_data        = data_q;
  assign rsp_status      = status_q;
  assign armed_vec       = armed_q;
endmodule

// File: tb/tb_collapse_arbiter.sv
// tb_collapse_arbiter: directed stimulus with a transaction-level model checked every cycle.
module tb_collapse_arbiter;
  localparam int L = 1;
  localparam bit INIT = 1'b0, READ = 1'b1;
  logic clk, rst_n;
  logic [1:0] req_valid, req_ready, req_op, rsp_valid, rsp_ready, rsp_status;
  logic [11:0] req_addr;
  logic [511:0] req_value;
  logic [15:0] req_basis;
  logic [255:0] rsp_data, bank_init_value, bank_data;
  logic [5:0] bank_init_addr, bank_read_addr;
  logic [7:0] bank_init_basis, bank_basis;
  logic bank_init_strobe, bank_read_pulse;
  logic [63:0] bank_mismatch_vec, armed_vec;
  logic v0, v1, op0, op1;
  logic [5:0] a0, a1;
  logic [255:0] val0, val1;
  logic [7:0] b0, b1;
  assign req_valid = {v1, v0};
  assign req_op    = {op1, op0};
  assign req_addr  = {a1, a0};
  assign req_value = {val1, val0};
  assign req_basis = {b1, b0};

  collapse_arbiter #(.N(64), .DATA_W(256), .BASIS_W(8), .ADDR_W(6), .READ_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_value(req_value), .req_basis(req_basis), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .bank_init_addr(bank_init_addr), .bank_init_value(bank_init_value),
    .bank_init_basis(bank_init_basis), .bank_init_strobe(bank_init_strobe),
    .bank_read_addr(bank_read_addr), .bank_basis(bank_basis), .bank_read_pulse(bank_read_pulse),
    .bank_data(bank_data), .bank_mismatch_vec(bank_mismatch_vec), .armed_vec(armed_vec));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0, npulse = 0;
  bit glog[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(negedge clk);
    if (bank_read_pulse) npulse++;
    if (|req_ready) glog.push_back(req_ready[1]);
  end

  // bank stand-in: stores INIT writes, returns data READ_LAT(=1) cycle after a pulse, noise otherwise
  logic [255:0] bank_mem [64];
  initial begin
    bit p;
    logic [5:0] ra;
    bank_data = '0;
    forever begin
      @(negedge clk);
      p  = bank_read_pulse;
      ra = bank_read_addr;
      if (bank_init_strobe) bank_mem[bank_init_addr] = bank_init_value;
      @(posedge clk);
      #1;
      bank_data = p ? bank_mem[ra] : {8{$urandom}};
    end
  end

  // transaction model: cycle t after acceptance -> ISSUE at t=1, response from t=2 (+L for a bank read)
  logic [255:0] m_mem [64];
  logic [63:0] m_armed;
  bit m_busy, m_en, m_last, m_r, m_op, m_hit, m_issue, m_wait, m_resp, m_g;
  int m_t, m_rsp_at;
  logic [5:0] m_addr;
  logic [7:0] m_basis;
  logic [255:0] m_val, m_exp_data;
  logic [1:0] m_exp_st, e_ready, e_rv;
  initial begin
    m_busy = 0; m_en = 0; m_last = 1; m_armed = '0; m_t = 0; m_rsp_at = 2;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ctrl", {req_ready, rsp_valid, rsp_status, bank_init_strobe, bank_read_pulse}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_init_bus", {bank_init_addr, bank_init_basis, bank_init_value[241:0]}, 0);
        chk("rst_read_bus", {bank_read_addr, bank_basis}, 0);
        chk("rst_armed", armed_vec, 0);
        m_busy = 0; m_en = 0; m_last = 1; m_armed = '0;
      end else begin
        m_g     = (&req_valid) ? !m_last : !req_valid[0];
        e_ready = (!m_busy && m_en && |req_valid) ? (2'b01 << m_g) : 2'b00;
        m_issue = m_busy && m_t == 1;
        m_resp  = m_busy && m_t > 1 && m_t >= m_rsp_at;
        m_wait  = m_busy && m_t > 1 && !m_resp;
        m_hit   = m_op && m_armed[m_addr];
        e_rv    = m_resp ? (2'b01 << m_r) : 2'b00;
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("init_strobe", bank_init_strobe, m_issue && !m_op);
        chk("read_pulse", bank_read_pulse, m_issue && m_hit);
        chk("exclusive", !(bank_init_strobe && bank_read_pulse) && !(&rsp_valid), 1);
        chk("armed_vec", armed_vec, m_armed);
        if (m_issue && !m_op) begin
          chk("init_addr_basis", {bank_init_addr, bank_init_basis}, {m_addr, m_basis});
          chk("init_value", bank_init_value, m_val);
        end
        if ((m_issue && m_hit) || m_wait)
          chk("read_bus", {bank_read_addr, bank_basis}, {m_addr, m_basis});
        if (!m_busy) begin
          chk("idle_read_bus", {bank_read_addr, bank_basis}, 0);
          chk("idle_rsp_data", rsp_data, 0);
        end
        if (m_resp) begin
          chk("rsp_data", rsp_data, m_exp_data);
          chk("rsp_status", rsp_status, m_exp_st);
        end
        if (!m_busy) begin
          if (e_ready != 0) begin
            m_busy = 1; m_t = 1; m_r = m_g; m_last = m_g;
            m_op    = req_op[m_g];
            m_addr  = m_g ? req_addr[11:6] : req_addr[5:0];
            m_val   = m_g ? req_value[511:256] : req_value[255:0];
            m_basis = m_g ? req_basis[15:8] : req_basis[7:0];
          end
        end else begin
          if (m_issue) begin
            if (!m_op) begin
              m_armed[m_addr] = 1'b1; m_mem[m_addr] = m_val;
              m_exp_data = '0; m_exp_st = 2'b00; m_rsp_at = 2;
            end else if (!m_hit) begin
              m_exp_data = '0; m_exp_st = 2'b10; m_rsp_at = 2;
            end else begin
              m_armed[m_addr] = 1'b0; m_exp_data = m_mem[m_addr];
              m_exp_st = bank_mismatch_vec[m_addr] ? 2'b01 : 2'b00; m_rsp_at = 2 + L;
            end
          end
          if (m_resp && rsp_ready[m_r]) m_busy = 0;
          m_t++;
        end
        m_en = 1;
      end
    end
  end

  task automatic set_req(input bit r, input bit v, input bit op, input logic [5:0] a,
                         input logic [255:0] val, input logic [7:0] b);
    if (r) begin v1 = v; op1 = op; a1 = a; val1 = val; b1 = b; end
    else begin v0 = v; op0 = op; a0 = a; val0 = val; b0 = b; end
  endtask

  task automatic send(input bit r, input bit op, input logic [5:0] a, input logic [255:0] val,
                      input logic [7:0] b, output int acc);
    set_req(r, 1'b1, op, a, val, b);
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin acc = cyc; break; end
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    set_req(r, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_rsp(input bit r, output logic [255:0] d, output logic [1:0] s, output int vc);
    vc = -1; d = '0; s = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid[r]) begin d = rsp_data; s = rsp_status; vc = cyc; break; end
    end
    if (vc < 0) chk("rsp_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] VA5 = {32{8'hA5}};
  localparam logic [255:0] VDB = {8{32'hDEADBEEF}};
  localparam logic [255:0] V7  = {16{16'h7707}};
  int rel, acc, acc0, acc1, vc, base, p0;
  logic [255:0] d;
  logic [1:0] s;
  initial begin
    rst_n = 0; rsp_ready = 2'b11; bank_mismatch_vec = '0;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1; rel = cyc;
    // INIT then destructive READ of cell 5
    send(0, INIT, 6'd5, VA5, 8'h3C, acc);
    chk("first_grant_not_first_edge", (acc - rel) >= 1, 1);
    wait_rsp(0, d, s, vc);
    chk("init_status", s, 2'b00);
    chk("init_latency", vc - acc, 2);
    chk("armed5_set", armed_vec[5], 1);
    p0 = npulse;
    send(0, READ, 6'd5, '0, 8'h3C, acc);
    wait_rsp(0, d, s, vc);
    chk("read_data", d, VA5);
    chk("read_status", s, 2'b00);
    chk("read_latency", vc - acc, 3);
    chk("read_pulses", npulse - p0, 1);
    chk("armed5_clear", armed_vec[5], 0);
    p0 = npulse;
    send(0, READ, 6'd5, '0, 8'h3C, acc);
    wait_rsp(0, d, s, vc);
    chk("empty_status", s, 2'b10);
    chk("empty_data", d, 0);
    chk("empty_pulses", npulse - p0, 0);
    // mismatch ground on the top cell, driven by requester 1
    bank_mismatch_vec = 64'h1 << 63;
    send(1, INIT, 6'd63, VDB, 8'h01, acc);
    wait_rsp(1, d, s, vc);
    send(1, READ, 6'd63, '0, 8'h01, acc);
    wait_rsp(1, d, s, vc);
    chk("mismatch_status", s, 2'b01);
    chk("mismatch_data", d, VDB);
    bank_mismatch_vec = '0;
    // both requesters busy: grants alternate starting with 0 (1 was served last)
    base = glog.size();
    fork
      begin send(0, INIT, 6'd10, {8{32'h10101010}}, 8'h0A, acc0); send(0, READ, 6'd10, '0, 8'h0A, acc0); end
      begin send(1, INIT, 6'd20, {8{32'h20202020}}, 8'h14, acc1); send(1, READ, 6'd20, '0, 8'h14, acc1); end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("alt_count", glog.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < glog.size()) chk("alt_grant", glog[base + i], i[0]);
    // response back-pressure
    send(0, INIT, 6'd7, V7, 8'h77, acc);
    wait_rsp(0, d, s, vc);
    rsp_ready = 2'b10;
    send(0, READ, 6'd7, '0, 8'h77, acc);
    fork send(1, INIT, 6'd8, {8{32'h88888888}}, 8'h08, acc1); join_none
    vc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin vc = cyc; break; end
    end
    chk("stall_seen", vc >= 0, 1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 2'b01);
      chk("stall_data", rsp_data, V7);
      chk("stall_ready", req_ready, 2'b00);
    end
    @(posedge clk);
    #1; rsp_ready = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    chk("armed8_set", armed_vec[8], 1);
    // reset lands in the WAIT cycle of a bank read
    send(0, INIT, 6'd9, {8{32'h99999999}}, 8'h09, acc);
    wait_rsp(0, d, s, vc);
    send(0, READ, 6'd9, '0, 8'h09, acc);
    @(posedge clk);
    #2;
    chk("wait_read_addr", bank_read_addr, 6'd9);
    rst_n = 0;
    #1;
    chk("async_ctrl", {req_ready, rsp_valid, rsp_status, bank_init_strobe, bank_read_pulse}, 0);
    chk("async_read_bus", {bank_read_addr, bank_basis}, 0);
    chk("async_rsp_data", rsp_data, 0);
    chk("async_armed", armed_vec, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    base = glog.size();
    fork
      send(1, INIT, 6'd11, {8{32'h11111111}}, 8'h0B, acc1);
      send(0, INIT, 6'd12, {8{32'h12121212}}, 8'h0C, acc0);
    join
    repeat (6) @(posedge clk);
    #1;
    if (glog.size() > base) chk("post_reset_grant", glog[base], 0);
    else chk("post_reset_grant_missing", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/collapse_arbiter.md
COLLAPSE_ARBITER -- requirements
Module: collapse_arbiter

Interface
REQ-001 Parameters SHALL be: N, 64, cells in bank; DATA_W, 256, cell data width; BASIS_W, 8, basis width; ADDR_W, $clog2(N), cell address width; READ_LAT, 1, cycles from bank_read_pulse to valid bank_data (range 1..4).
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester command valid.
- req_ready  out  2  per-requester command accept.
- req_op  in  2  per requester: 0 = INIT, 1 = READ.
- req_addr  in  2*ADDR_W  per-requester cell address (requester r at [r*ADDR_W +: ADDR_W]).
- req_value  in  2*DATA_W  per-requester INIT value.
- req_basis  in  2*BASIS_W  per-requester INIT/READ basis.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  DATA_W  response data (shared).
- rsp_status  out  2  00 OK, 01 MISMATCH, 10 EMPTY.
- bank_init_addr / bank_init_value / bank_init_basis  out  ADDR_W / DATA_W / BASIS_W  bank INIT bus.
- bank_init_strobe  out  1  bank INIT strobe.
- bank_read_addr / bank_basis  out  ADDR_W / BASIS_W  bank READ bus.
- bank_read_pulse  out  1  bank READ pulse.
- bank_data  in  DATA_W  bank read data.
- bank_mismatch_vec  in  N  per-cell mismatch-ground flags.
- armed_vec  out  N  per-cell "initialised, not yet read" bitmap.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one command in flight at a time.
REQ-004 IDLE: when any req_valid is high, the arbiter SHALL grant one requester by round-robin (priority to the requester not granted last; requester 0 first after reset), assert req_ready[grant] for exactly that cycle, latch op/addr/value/basis, and go to ISSUE.
REQ-005 req_ready SHALL be high only in IDLE and only for the granted requester; commands SHALL NOT be accepted in any other state.
REQ-006 ISSUE, INIT: assert bank_init_strobe for exactly one cycle with latched addr/value/basis; set armed_vec[addr]; go to RESP with status OK and rsp_data = 0.
REQ-007 ISSUE, READ with armed_vec[addr] = 0: no bank pulse; go to RESP with status EMPTY and rsp_data = 0.
REQ-008 ISSUE, READ with armed_vec[addr] = 1: assert bank_read_pulse for exactly one cycle; clear armed_vec[addr]; go to WAIT.
REQ-009 bank_read_addr and bank_basis SHALL hold the latched values from ISSUE until the WAIT capture cycle inclusive; they are 0 in IDLE.
REQ-010 WAIT SHALL last READ_LAT cycles. On the last cycle, capture bank_data into rsp_data and bank_mismatch_vec[addr] into status (1 -> MISMATCH, else OK); then go to RESP.
REQ-011 RESP: hold rsp_valid[grant] with stable rsp_data/rsp_status until rsp_ready[grant]. On the handshake cycle, go to IDLE and clear rsp_data to 0.
REQ-012 Minimum latency, accept-to-rsp_valid: INIT/EMPTY 2 cycles; READ 2 + READ_LAT cycles.
REQ-013 INIT to an armed cell SHALL overwrite it (strobe issued, status OK).
REQ-014 A READ of a cell SHALL be destructive exactly once per INIT; a second READ returns EMPTY without a bank pulse.
REQ-015 With both requesters valid continuously, grants SHALL alternate 0,1,0,1. A requester deasserting req_valid before grant SHALL lose nothing.
REQ-016 bank_init_strobe and bank_read_pulse SHALL never be asserted in the same cycle.
REQ-017 rsp_valid SHALL never be high for both requesters simultaneously.

Reset
REQ-018 While rst_n = 0, all outputs SHALL be 0: req_ready, rsp_valid, rsp_data, rsp_status, all bank_* outputs, armed_vec. The FSM SHALL be in IDLE and round-robin pointer = requester 0.
REQ-019 Reset mid-command SHALL abandon the command without pulsing the bank afterwards. Any pulse in progress SHALL deassert asynchronously.
REQ-020 The first grant SHALL occur no earlier than the second rising clk edge after rst_n deasserts.

Verification
REQ-021 Bench SHALL cover:
- Req0 INIT addr 5, value 0xA5..A5, then Req0 READ addr 5 (READ_LAT=1, mismatch=0) -> one bank_read_pulse; rsp_data = 0xA5..A5; status OK; rsp_valid 3 cycles after accept; armed_vec[5] 1->0.
- Second READ addr 5 -> status EMPTY, rsp_data 0, no bank_read_pulse.
- Both requesters valid for 4 commands -> grants 0,1,0,1; never two rsp_valid.
- READ addr 63 with bank_mismatch_vec[63] = 1 -> status MISMATCH.
- rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable; no new req_ready.
- rst_n low during WAIT -> all outputs 0 immediately; armed_vec cleared; next command grants requester 0.
